// File: rtl/reg_file_mp.sv
// Multi-port register file: registered reads with write-first bypass, per-register busy scoreboard.
// Optional macro REG_FILE_ZERO_REG_EN hardwires register 0 to zero (data and busy).
module reg_file_mp #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_RD-1:0]              i_rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   i_rd_addr,
  output logic [NUM_RD*REG_WIDTH-1:0]    o_rd_data,
  output logic [NUM_RD-1:0]              o_rd_busy,
  input  logic [NUM_WR-1:0]              i_wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]   i_wr_addr,
  input  logic [NUM_WR*REG_WIDTH-1:0]    i_wr_data,
  input  logic                           i_rsv_en,
  input  logic [ADDR_WIDTH-1:0]          i_rsv_addr,
  output logic [ADDR_WIDTH:0]            o_busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [REG_WIDTH-1:0] regs     [DEPTH];
  logic [REG_WIDTH-1:0] regs_nxt [DEPTH];
  logic [DEPTH-1:0]     busy;
  logic [DEPTH-1:0]     busy_nxt;
  logic [ADDR_WIDTH:0]  cnt_nxt;

  // Post-edge state; reads sample it directly, which gives write-first bypass.
  // Ports are applied in ascending order so the highest-indexed writer wins,
  // and the reservation is applied last so it overrides a same-edge write.
  always_comb begin
    regs_nxt = regs;
    busy_nxt = busy;
    for (int w = 0; w < NUM_WR; w++) begin
      if (i_wr_en[w]) begin
        regs_nxt[i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = i_wr_data[w*REG_WIDTH +: REG_WIDTH];
        busy_nxt[i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
    end
    if (i_rsv_en) begin
      busy_nxt[i_rsv_addr] = 1'b1;
    end
`ifdef REG_FILE_ZERO_REG_EN
    regs_nxt[0] = '0;
    busy_nxt[0] = 1'b0;
`endif
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_WIDTH+1)'(busy_nxt[i]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy       <= '0;
      o_busy_cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= regs_nxt[i];
      end
      busy       <= busy_nxt;
      o_busy_cnt <= cnt_nxt;
    end
  end

  // Read ports hold their last result while disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_data <= '0;
      o_rd_busy <= '0;
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        if (i_rd_en[k]) begin
          o_rd_data[k*REG_WIDTH +: REG_WIDTH] <= regs_nxt[i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
          o_rd_busy[k]                        <= busy_nxt[i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (2 read / 2 write ports, 32 x 32 bits).
// Expected values for the zero-register case follow REG_FILE_ZERO_REG_EN.
module tb_reg_file_mp;

  localparam int RW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic [1:0]    rd_en;
  logic [2*AW-1:0] rd_addr;
  logic [2*RW-1:0] rd_data;
  logic [1:0]    rd_busy;
  logic [1:0]    wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*RW-1:0] wr_data;
  logic          rsv_en;
  logic [AW-1:0] rsv_addr;
  logic [AW:0]   busy_cnt;

  int checks = 0;
  int errors = 0;

  reg_file_mp #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .NUM_RD(2), .NUM_WR(2)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rd_en    (rd_en),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_rd_busy  (rd_busy),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_rsv_en   (rsv_en),
    .i_rsv_addr (rsv_addr),
    .o_busy_cnt (busy_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  logic [31:0] zexp_data;
  logic        zexp_busy;
  logic [AW:0] zexp_cnt;

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    check("reset_rd_data0", rd_data[31:0], 32'h0);
    check("reset_rd_data1", rd_data[63:32], 32'h0);
    check("reset_rd_busy", 32'(rd_busy), 32'h0);
    check("reset_busy_cnt", 32'(busy_cnt), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Every address on both ports after reset.
    for (int a = 0; a < 32; a++) begin
      rd_en = 2'b11;
      rd_addr = {5'(31 - a), 5'(a)};
      tick();
      check("init_rd0", rd_data[31:0], 32'h0);
      check("init_rd1", rd_data[63:32], 32'h0);
      check("init_busy", 32'(rd_busy), 32'h0);
      check("init_cnt", 32'(busy_cnt), 32'h0);
    end

    // Same-edge bypass; port 0 disabled must hold its last value.
    rd_en = 2'b00; rd_addr = {5'd7, 5'd0};
    rd_en[1] = 1'b1;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'hDEADBEEF};
    tick();
    check("bypass_rd1", rd_data[63:32], 32'hDEADBEEF);
    check("hold_rd0", rd_data[31:0], 32'h0);
    rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    tick();
    check("stored_rd0", rd_data[31:0], 32'hDEADBEEF);
    check("hold_rd1", rd_data[63:32], 32'hDEADBEEF);

    // Write collision: highest port wins.
    wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h22, 32'h11};
    tick();
    rd_en = 2'b11; rd_addr = {5'd3, 5'd3};
    tick();
    check("collide_rd0", rd_data[31:0], 32'h22);
    check("collide_rd1", rd_data[63:32], 32'h22);
    wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'h44, 32'h33};
    rd_en = 2'b11; rd_addr = {5'd9, 5'd9};
    tick();
    check("collide_bypass0", rd_data[31:0], 32'h44);
    check("collide_bypass1", rd_data[63:32], 32'h44);

    // Scoreboard: reserve, clear by write, reserve beats write.
    rsv_en = 1'b1; rsv_addr = 5'd5;
    tick();
    check("rsv_cnt", 32'(busy_cnt), 32'd1);
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    tick();
    check("rsv_rd_busy", 32'(rd_busy[0]), 32'd1);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hA5};
    rd_en = 2'b10; rd_addr = {5'd5, 5'd0};
    tick();
    check("wr_clear_busy", 32'(rd_busy[1]), 32'd0);
    check("wr_clear_data", rd_data[63:32], 32'hA5);
    check("wr_clear_cnt", 32'(busy_cnt), 32'd0);
    check("hold_busy0", 32'(rd_busy[0]), 32'd1);
    rsv_en = 1'b1; rsv_addr = 5'd5;
    wr_en = 2'b10; wr_addr = {5'd5, 5'd0}; wr_data = {32'hA5, 32'h0};
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    tick();
    check("rsv_wins_busy", 32'(rd_busy[0]), 32'd1);
    check("rsv_wins_data", rd_data[31:0], 32'hA5);
    check("rsv_wins_cnt", 32'(busy_cnt), 32'd1);

    // Three more reservations, then asynchronous reset mid-cycle.
    for (int r = 10; r < 13; r++) begin
      rsv_en = 1'b1; rsv_addr = 5'(r);
      rd_en = 2'b11; rd_addr = {5'(r), 5'd7};
      tick();
    end
    check("pre_reset_cnt", 32'(busy_cnt), 32'd4);
    check("pre_reset_busy1", 32'(rd_busy[1]), 32'd1);
    check("pre_reset_rd0", rd_data[31:0], 32'hDEADBEEF);
    rsv_en = 1'b1; rsv_addr = 5'd20;
    rd_en = 2'b11; rd_addr = {5'd11, 5'd7};
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rd0", rd_data[31:0], 32'h0);
    check("async_rd1", rd_data[63:32], 32'h0);
    check("async_busy", 32'(rd_busy), 32'h0);
    check("async_cnt", 32'(busy_cnt), 32'h0);
    idle();
    #1;
    rst_n = 1'b1;
    rd_en = 2'b11; rd_addr = {5'd11, 5'd7};
    tick();
    check("post_reset_rd0", rd_data[31:0], 32'h0);
    check("post_reset_busy1", 32'(rd_busy[1]), 32'd0);
    check("post_reset_cnt", 32'(busy_cnt), 32'd0);

    // Register 0: write, reserve and bypass read on the same edge.
`ifdef REG_FILE_ZERO_REG_EN
    zexp_data = 32'h0; zexp_busy = 1'b0; zexp_cnt = '0;
`else
    zexp_data = 32'hFFFFFFFF; zexp_busy = 1'b1; zexp_cnt = 6'd1;
`endif
    wr_en = 2'b01; wr_addr = '0; wr_data = {32'h0, 32'hFFFFFFFF};
    rsv_en = 1'b1; rsv_addr = 5'd0;
    rd_en = 2'b01; rd_addr = '0;
    tick();
    check("zero_bypass_data", rd_data[31:0], zexp_data);
    check("zero_bypass_busy", 32'(rd_busy[0]), 32'(zexp_busy));
    rd_en = 2'b10; rd_addr = '0;
    tick();
    check("zero_read_data", rd_data[63:32], zexp_data);
    check("zero_read_busy", 32'(rd_busy[1]), 32'(zexp_busy));
    check("zero_cnt", 32'(busy_cnt), 32'(zexp_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file with registered reads, same-cycle write-to-read bypass and a per-register busy scoreboard. It is the datapath register store for the execution pipeline: the issue stage reads operands and reserves destinations, and the writeback stages retire results. It generalises the single-write, two-read register file to configurable width, depth and port counts.

## Interface
- REG_WIDTH, 32, bits per register
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH registers
- NUM_RD, 2, read ports
- NUM_WR, 2, write ports
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_rd_en  in  NUM_RD  per-port read enable
- i_rd_addr  in  NUM_RD*ADDR_WIDTH  read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- o_rd_data  out  NUM_RD*REG_WIDTH  registered read data, port k at [k*REG_WIDTH +: REG_WIDTH]
- o_rd_busy  out  NUM_RD  registered busy bit of the register read
- i_wr_en  in  NUM_WR  per-port write enable
- i_wr_addr  in  NUM_WR*ADDR_WIDTH  write addresses
- i_wr_data  in  NUM_WR*REG_WIDTH  write data
- i_rsv_en  in  1  reserve a destination register (sets busy)
- i_rsv_addr  in  ADDR_WIDTH  register to reserve
- o_busy_cnt  out  ADDR_WIDTH+1  number of registers currently busy

## Operation
- Storage: DEPTH x REG_WIDTH flops plus a DEPTH-bit busy vector.
- Write: on each edge, every port with i_wr_en high stores i_wr_data into i_wr_addr and clears that register's busy bit.
- Write collision: when two or more enabled ports target the same address, the highest-indexed port wins.
- Reserve: i_rsv_en sets busy[i_rsv_addr]. If the same edge also writes that address, the data is stored and busy ends up set, because the reservation wins.
- Read: on an edge where i_rd_en[k] is high, the port samples i_rd_addr[k] and loads o_rd_data[k] and o_rd_busy[k]. When i_rd_en[k] is low, both outputs hold their previous values.
- Bypass (write-first): if an enabled write targets the read address on the same edge, o_rd_data returns the new write data, using the winning port's data. o_rd_busy reflects the post-edge busy state, which accounts for both the write and any reservation.
- Multiple read ports may target the same address; all of them return identical data.
- o_busy_cnt equals the popcount of the busy vector after the edge and is registered.

## Timing
- Read latency: 1 cycle. The address presented before edge N produces data valid after edge N.
- Write latency: 1 cycle. The write is visible to a read sampled on the same edge through the bypass.
- Reservation latency: 1 cycle. The busy state is visible to a read on the same edge.
- Reset (i_rst_n low, asynchronous): every register, busy bit, o_rd_data, o_rd_busy and o_busy_cnt goes to 0 immediately.
- Reset deassertion: takes effect at the next clock edge. Reads in flight and reservations made before reset are discarded.
- No stalls and no backpressure: every port accepts a request every cycle.

## Configuration
- REG_FILE_ZERO_REG_EN defined: register 0 is hardwired to zero.
  - Writes to address 0 are dropped.
  - Reservations of address 0 are ignored, so busy[0] stays 0.
  - Reads of address 0 return 0 with busy 0, including under bypass.
- REG_FILE_ZERO_REG_EN undefined: register 0 behaves like every other register.

## Test plan
- Reset, then read all addresses on every port: all o_rd_data = 0, o_rd_busy = 0, o_busy_cnt = 0.
- Write 0xDEADBEEF to address 7 on port 0 while port 1 reads address 7 on the same edge: o_rd_data[1] = 0xDEADBEEF one cycle later.
- Ports 0 and 1 both write address 3 with 0x11 and 0x22 on one edge: a subsequent read returns 0x22.
- Reserve address 5: o_busy_cnt = 1 and a read returns busy = 1. Then write 0xA5 to address 5: busy = 0 and o_busy_cnt = 0. A reserve and a write to address 5 on the same edge leave busy = 1 with data = 0xA5.
- Assert i_rst_n low mid-stream, after three reservations and pending reads: all outputs read 0 before the next clock edge, and after release o_busy_cnt = 0.
- With REG_FILE_ZERO_REG_EN defined: write 0xFFFFFFFF to address 0 and reserve address 0, then read address 0: data = 0 and busy = 0. Without the macro, the same sequence returns 0xFFFFFFFF with busy = 1.
